seg7_bcd_seq: RTL and testbench

Sequential controller that converts an 8-bit binary value (0-255) to three BCD digits and drives three registered 7-segment displays. It accepts a value through a load/ready handshake and runs an 8-iteration shift-add-3 (double-dabble) loop, one bit per clock. It then latches the decoded segment patterns and pulses `done`. It sits between any value producer (counter, switch sampler, bus register) and the board's hundreds/tens/ones displays, replacing the combinational converter with a bounded-latency, registered path.

---
 rtl/seg7_bcd_seq_if.sv | 22 ++
 rtl/seg7_bcd_seq.sv | 132 +++++++++++++
 tb/tb_seg7_bcd_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_bcd_seq_if.sv
// Handshake and display bundle between a value producer and seg7_bcd_seq.
// The producer drives load/binary_number; the converter drives status and segments.
interface seg7_bcd_seq_if;
  logic       load;
  logic [7:0] binary_number;
  logic       ready;
  logic       busy;
  logic       done;
  logic [6:0] disp_hundreds;
  logic [6:0] disp_tens;
  logic [6:0] disp_ones;

  modport master (
    output load, binary_number,
    input  ready, busy, done, disp_hundreds, disp_tens, disp_ones
  );

  modport slave (
    input  load, binary_number,
    output ready, busy, done, disp_hundreds, disp_tens, disp_ones
  );
endinterface

// File: rtl/seg7_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock)
// with registered 7-segment outputs. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
module seg7_bcd_seq #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  state_t      state, state_nxt;
  logic [7:0]  shift_reg;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  bit_cnt;
  logic        done_q;
  logic [6:0]  disp_h_q, disp_t_q, disp_o_q;
  logic        ready_c;
  logic [3:0]  dig_h, dig_t, dig_o;

  // Nibble 4'hF (or any non-BCD code) decodes to an all-off pattern.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] low;
    case (digit)
      4'd0:    low = 7'b1000000;
      4'd1:    low = 7'b1111001;
      4'd2:    low = 7'b0100100;
      4'd3:    low = 7'b0110000;
      4'd4:    low = 7'b0011001;
      4'd5:    low = 7'b0010010;
      4'd6:    low = 7'b0000010;
      4'd7:    low = 7'b1111000;
      4'd8:    low = 7'b0000000;
      4'd9:    low = 7'b0011000;
      default: low = 7'b1111111;
    endcase
    return ACTIVE_LOW ? low : ~low;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    dig_h = bcd[11:8];
    dig_t = bcd[7:4];
    dig_o = bcd[3:0];
`ifdef SEG7_LZ_BLANK_EN
    if (bcd[11:8] == 4'd0) begin
      dig_h = 4'hF;
      if (bcd[7:4] == 4'd0) dig_t = 4'hF;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.load) state_nxt = S_SHIFT;
      S_SHIFT:  if (bit_cnt == 3'd7) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_c = (state == S_IDLE);
  end

  // Datapath: capture, shift-add-3 iterations, display latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      done_q    <= 1'b0;
      disp_h_q  <= BLANK;
      disp_t_q  <= BLANK;
      disp_o_q  <= BLANK;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load) begin
            shift_reg <= bus.binary_number;
            bcd       <= '0;
            bit_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          {bcd, shift_reg} <= {bcd_adj, shift_reg} << 1;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        S_UPDATE: begin
          disp_h_q <= seg_encode(dig_h);
          disp_t_q <= seg_encode(dig_t);
          disp_o_q <= seg_encode(dig_o);
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready         = ready_c;
  assign bus.busy          = ~ready_c;
  assign bus.done          = done_q;
  assign bus.disp_hundreds = disp_h_q;
  assign bus.disp_tens     = disp_t_q;
  assign bus.disp_ones     = disp_o_q;

endmodule

// File: tb/tb_seg7_bcd_seq.sv
// Self-checking bench for seg7_bcd_seq: vector table, random values against an
// arithmetic reference model, and hand-written handshake/reset sequences.
module tb_seg7_bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_bcd_seq_if bus ();

  seg7_bcd_seq #(.ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] C0 = 7'b1000000, C1 = 7'b1111001, C2 = 7'b0100100,
                         C3 = 7'b0110000, C4 = 7'b0011001, C5 = 7'b0010010,
                         C6 = 7'b0000010, C7 = 7'b1111000, C8 = 7'b0000000,
                         C9 = 7'b0011000;

  typedef struct {
    logic [7:0] value;
    logic [6:0] h;
    logic [6:0] t;
    logic [6:0] o;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by division, segment codes from a lookup list.
  function automatic logic [20:0] model(input int v);
    logic [6:0] lut [10];
    int h, t, o;
    logic [6:0] ph, pt, po;
    lut = '{C0, C1, C2, C3, C4, C5, C6, C7, C8, C9};
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    ph = lut[h];
    pt = lut[t];
    po = lut[o];
`ifdef SEG7_LZ_BLANK_EN
    if (h == 0) ph = BL;
    if (h == 0 && t == 0) pt = BL;
`endif
    return {ph, pt, po};
  endfunction

  function automatic logic [20:0] displays();
    return {bus.disp_hundreds, bus.disp_tens, bus.disp_ones};
  endfunction

  // One conversion with bounded wait; checks handshake and latency, returns displays.
  task automatic run_conv(input logic [7:0] v, input string tag, output logic [20:0] disp);
    int lat;
    bit early;
    bus.binary_number = v;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    bus.binary_number = 8'($urandom);
    check($sformatf("%s ready_after_accept", tag), 32'(bus.ready), 32'd0);
    lat = 0;
    early = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (bus.done) lat = c;
      else if (bus.ready) early = 1'b1;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd9);
    check($sformatf("%s ready_low_while_busy", tag), 32'(early), 32'd0);
    check($sformatf("%s ready_with_done", tag), 32'(bus.ready), 32'd1);
    disp = displays();
    tick();
    check($sformatf("%s done_one_cycle", tag), 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [$];
    logic [20:0] d;
    int         ndone, first, second;
    logic [7:0] rv;

    bus.load = 1'b0;
    bus.binary_number = 8'd0;
    rst_n = 1'b0;
    #12;
    check("reset displays", 32'(displays()), 32'({BL, BL, BL}));
    #5 rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle%0d ready", i), 32'(bus.ready), 32'd1);
      check($sformatf("idle%0d busy", i), 32'(bus.busy), 32'd0);
      check($sformatf("idle%0d done", i), 32'(bus.done), 32'd0);
      check($sformatf("idle%0d displays", i), 32'(displays()), 32'({BL, BL, BL}));
    end

    // Directed vector table
    vecs.push_back('{8'd255, C2, C5, C5});
    vecs.push_back('{8'd109, C1, C0, C9});
    vecs.push_back('{8'd200, C2, C0, C0});
`ifdef SEG7_LZ_BLANK_EN
    vecs.push_back('{8'd7,  BL, BL, C7});
    vecs.push_back('{8'd0,  BL, BL, C0});
    vecs.push_back('{8'd42, BL, C4, C2});
    vecs.push_back('{8'd10, BL, C1, C0});
    vecs.push_back('{8'd99, BL, C9, C9});
`else
    vecs.push_back('{8'd7,  C0, C0, C7});
    vecs.push_back('{8'd0,  C0, C0, C0});
    vecs.push_back('{8'd42, C0, C4, C2});
    vecs.push_back('{8'd10, C0, C1, C0});
    vecs.push_back('{8'd99, C0, C9, C9});
`endif
    vecs.push_back('{8'd138, C1, C3, C8});
    vecs.push_back('{8'd56, (`ifdef SEG7_LZ_BLANK_EN BL `else C0 `endif), C5, C6});
    foreach (vecs[i]) begin
      run_conv(vecs[i].value, $sformatf("vec%0d", vecs[i].value), d);
      check($sformatf("vec%0d hundreds", vecs[i].value), 32'(d[20:14]), 32'(vecs[i].h));
      check($sformatf("vec%0d tens", vecs[i].value), 32'(d[13:7]), 32'(vecs[i].t));
      check($sformatf("vec%0d ones", vecs[i].value), 32'(d[6:0]), 32'(vecs[i].o));
    end

    // Random values against the reference model
    for (int i = 0; i < 30; i++) begin
      rv = 8'($urandom_range(0, 255));
      run_conv(rv, $sformatf("rnd%0d", rv), d);
      check($sformatf("rnd%0d displays", rv), 32'(d), 32'(model(int'(rv))));
      repeat ($urandom_range(0, 3)) tick();
    end

    // Load during busy is dropped
    bus.binary_number = 8'd109;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (3) tick();
    bus.binary_number = 8'd42;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 5; c <= 25; c++) begin
      if (bus.done) begin
        ndone++;
        if (first == 0) first = c - 1;
      end
      tick();
    end
    check("ignored_load done_count", 32'(ndone), 32'd1);
    check("ignored_load done_edge", 32'(first), 32'd9);
    check("ignored_load displays", 32'(displays()), 32'(model(109)));

    // Back-to-back with load held high
    bus.binary_number = 8'd0;
    bus.load = 1'b1;
    tick();
    bus.binary_number = 8'd200;
    ndone = 0;
    first = 0;
    second = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 10) bus.load = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first == 0) begin
          first = c;
          check("b2b first displays", 32'(displays()), 32'(model(0)));
        end else if (second == 0) begin
          second = c;
          check("b2b second displays", 32'(displays()), 32'(model(200)));
        end
      end
    end
    check("b2b done_count", 32'(ndone), 32'd2);
    check("b2b first_edge", 32'(first), 32'd9);
    check("b2b second_edge", 32'(second), 32'd19);

    // Reset mid-conversion
    run_conv(8'd255, "pre_reset", d);
    check("pre_reset displays", 32'(d), 32'(model(255)));
    bus.binary_number = 8'd128;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midreset displays", 32'(displays()), 32'({BL, BL, BL}));
    check("midreset ready", 32'(bus.ready), 32'd1);
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("postreset no_done", 32'(ndone), 32'd0);
    check("postreset displays", 32'(displays()), 32'({BL, BL, BL}));
    check("postreset ready", 32'(bus.ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
